// File: rtl/mem_wr_burst_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_wr_burst_ctrl_if
//
// Bundles every non-clock signal of the DDR4 write-burst controller:
//   - request handshake from the image-interface chain
//       init_calib_complete, mem_wr_req, mem_wr_addr[28:0], mem_wr_ack
//   - upstream FWFT FIFO
//       fifo_rd_data_count[8:0], mem_wdata_rd_en, mem_wdf_data[127:0]
//   - MIG command channel
//       app_en, app_cmd[2:0], app_addr[28:0], app_rdy
//   - MIG write-data channel
//       app_wdf_wren, app_wdf_end, app_wdf_data[127:0], app_wdf_mask[15:0],
//       app_wdf_rdy
//   - status
//       busy, bursts_done[15:0]
//
// Modports:
//   slave  - the burst controller (serves requests, drives the MIG app bus)
//   master - the surrounding system (upstream, FIFO, MIG model)
// -----------------------------------------------------------------------------
interface mem_wr_burst_ctrl_if;

    // Request handshake
    logic         init_calib_complete;
    logic         mem_wr_req;
    logic [28:0]  mem_wr_addr;
    logic         mem_wr_ack;

    // Upstream FWFT FIFO
    logic [8:0]   fifo_rd_data_count;
    logic         mem_wdata_rd_en;
    logic [127:0] mem_wdf_data;

    // MIG command channel
    logic         app_en;
    logic [2:0]   app_cmd;
    logic [28:0]  app_addr;
    logic         app_rdy;

    // MIG write-data channel
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_rdy;

    // Status
    logic         busy;
    logic [15:0]  bursts_done;

    modport slave (
        input  init_calib_complete,
        input  mem_wr_req,
        input  mem_wr_addr,
        output mem_wr_ack,
        input  fifo_rd_data_count,
        output mem_wdata_rd_en,
        input  mem_wdf_data,
        output app_en,
        output app_cmd,
        output app_addr,
        input  app_rdy,
        output app_wdf_wren,
        output app_wdf_end,
        output app_wdf_data,
        output app_wdf_mask,
        input  app_wdf_rdy,
        output busy,
        output bursts_done
    );

    modport master (
        output init_calib_complete,
        output mem_wr_req,
        output mem_wr_addr,
        input  mem_wr_ack,
        output fifo_rd_data_count,
        input  mem_wdata_rd_en,
        output mem_wdf_data,
        input  app_en,
        input  app_cmd,
        input  app_addr,
        output app_rdy,
        input  app_wdf_wren,
        input  app_wdf_end,
        input  app_wdf_data,
        input  app_wdf_mask,
        output app_wdf_rdy,
        input  busy,
        input  bursts_done
    );

endinterface

// File: rtl/mem_wr_burst_ctrl.sv
// -----------------------------------------------------------------------------
// mem_wr_burst_ctrl
//
// Write-side controller between the camera image-interface chain and the MIG
// DDR4 user interface. One burst request is accepted at a time; each burst
// issues BURST_BEATS write commands and BURST_BEATS 128-bit data beats, the
// data being drained from the selected camera FIFO (first-word-fall-through).
// Everything runs on the MIG user clock.
//
// Parameters:
//   BURST_BEATS - 128-bit beats per request (1..256)
//   ADDR_INCR   - app_addr increment per command beat
//
// Ports:
//   mem_clk   - MIG user clock, rising edge
//   mem_reset - asynchronous, active-high reset
//   bus       - mem_wr_burst_ctrl_if.slave (handshake, FIFO, MIG, status)
//
// The command and data channels are counted independently (cmd_left_r,
// data_left_r) so data can run ahead of commands and commands never wait
// for data. The burst ends only when both counters are zero.
// -----------------------------------------------------------------------------
module mem_wr_burst_ctrl #(
    parameter int BURST_BEATS = 64,
    parameter int ADDR_INCR   = 8
) (
    input  logic                  mem_clk,
    input  logic                  mem_reset,
    mem_wr_burst_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    // 9-bit counters so that BURST_BEATS = 256 loads as 9'd256.
    localparam logic [8:0]  BEATS_C = 9'(BURST_BEATS);
    localparam logic [28:0] INCR_C  = 29'(ADDR_INCR);

    state_t        state_r;
    logic [8:0]    cmd_left_r;
    logic [8:0]    data_left_r;
    logic [28:0]   app_addr_r;
    logic          app_en_r;
    logic          app_wdf_wren_r;
    logic          app_wdf_end_r;
    logic          mem_wr_ack_r;
    logic          busy_r;
    logic [15:0]   bursts_done_r;

    logic          start_s;
    logic          cmd_fire_s;
    logic          data_fire_s;
    logic [8:0]    cmd_left_nxt_s;
    logic [8:0]    data_left_nxt_s;

    // Acceptance condition and per-channel transfer / remaining-count terms.
    always_comb begin
        start_s         = bus.mem_wr_req & bus.init_calib_complete &
                          (bus.fifo_rd_data_count >= BEATS_C);
        cmd_fire_s      = app_en_r & bus.app_rdy;
        data_fire_s     = app_wdf_wren_r & bus.app_wdf_rdy;
        cmd_left_nxt_s  = cmd_left_r  - {8'd0, cmd_fire_s};
        data_left_nxt_s = data_left_r - {8'd0, data_fire_s};
    end

    // Burst FSM with all strobes registered from the next-state counters,
    // so app_en tracks (cmd_left != 0) and app_wdf_wren tracks (data_left != 0).
    always_ff @(posedge mem_clk or posedge mem_reset) begin
        if (mem_reset) begin
            state_r        <= IDLE;
            cmd_left_r     <= 9'd0;
            data_left_r    <= 9'd0;
            app_addr_r     <= 29'd0;
            app_en_r       <= 1'b0;
            app_wdf_wren_r <= 1'b0;
            app_wdf_end_r  <= 1'b0;
            mem_wr_ack_r   <= 1'b0;
            busy_r         <= 1'b0;
            bursts_done_r  <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r        <= BURST;
                        app_addr_r     <= bus.mem_wr_addr;
                        cmd_left_r     <= BEATS_C;
                        data_left_r    <= BEATS_C;
                        app_en_r       <= 1'b1;
                        app_wdf_wren_r <= 1'b1;
                        app_wdf_end_r  <= 1'b1;
                        mem_wr_ack_r   <= 1'b1;
                        busy_r         <= 1'b1;
                    end else begin
                        state_r        <= IDLE;
                        app_en_r       <= 1'b0;
                        app_wdf_wren_r <= 1'b0;
                        app_wdf_end_r  <= 1'b0;
                        mem_wr_ack_r   <= 1'b0;
                        busy_r         <= 1'b0;
                    end
                end

                BURST: begin
                    // Calibration and mem_wr_req are deliberately not looked
                    // at here: an accepted burst always runs to completion.
                    mem_wr_ack_r   <= 1'b0;
                    busy_r         <= 1'b1;
                    cmd_left_r     <= cmd_left_nxt_s;
                    data_left_r    <= data_left_nxt_s;
                    app_en_r       <= (cmd_left_nxt_s != 9'd0);
                    app_wdf_wren_r <= (data_left_nxt_s != 9'd0);
                    app_wdf_end_r  <= (data_left_nxt_s != 9'd0);
                    if (cmd_fire_s) begin
                        app_addr_r <= app_addr_r + INCR_C;
                    end else begin
                        app_addr_r <= app_addr_r;
                    end
                    if ((cmd_left_nxt_s == 9'd0) && (data_left_nxt_s == 9'd0)) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= BURST;
                    end
                end

                DONE: begin
                    // One quiet cycle lets upstream update address and FIFO
                    // count before mem_wr_req is sampled again in IDLE.
                    state_r        <= IDLE;
                    bursts_done_r  <= bursts_done_r + 16'd1;
                    busy_r         <= 1'b0;
                    mem_wr_ack_r   <= 1'b0;
                    app_en_r       <= 1'b0;
                    app_wdf_wren_r <= 1'b0;
                    app_wdf_end_r  <= 1'b0;
                end

                default: begin
                    state_r        <= IDLE;
                    cmd_left_r     <= 9'd0;
                    data_left_r    <= 9'd0;
                    app_en_r       <= 1'b0;
                    app_wdf_wren_r <= 1'b0;
                    app_wdf_end_r  <= 1'b0;
                    mem_wr_ack_r   <= 1'b0;
                    busy_r         <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_wr_ack      = mem_wr_ack_r;
    assign bus.app_en          = app_en_r;
    assign bus.app_cmd         = 3'b000;
    assign bus.app_addr        = app_addr_r;
    assign bus.app_wdf_wren    = app_wdf_wren_r;
    assign bus.app_wdf_end     = app_wdf_end_r;
    // FWFT head word goes straight to the MIG; it only advances on a pop,
    // so it holds naturally while app_wdf_rdy is low.
    assign bus.app_wdf_data    = bus.mem_wdf_data;
    assign bus.app_wdf_mask    = 16'h0000;
    assign bus.mem_wdata_rd_en = data_fire_s;
    assign bus.busy            = busy_r;
    assign bus.bursts_done     = bursts_done_r;

endmodule

// File: tb/tb_mem_wr_burst_ctrl.sv
module tb_mem_wr_burst_ctrl;

    localparam int BB = 4;

    logic mem_clk;
    logic mem_reset;

    mem_wr_burst_ctrl_if ifc ();

    mem_wr_burst_ctrl #(.BURST_BEATS(BB), .ADDR_INCR(8)) dut (
        .mem_clk   (mem_clk),
        .mem_reset (mem_reset),
        .bus       (ifc.slave)
    );

    always #5 mem_clk = ~mem_clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // Scoreboard queues filled by the stimulus
    logic [28:0]  exp_cmd  [$];
    logic [28:0]  exp_ack  [$];
    logic [127:0] exp_data [$];
    logic [127:0] fifo_q   [$];

    // Monitor bookkeeping
    int          ack_count     = 0;
    int          last_ack_cyc  = 0;
    int          ack_cyc_q [$];
    int          idle_cyc      = 0;
    int          burst_count   = 0;
    int          pop_total     = 0;
    int          cmd_since_ack = 0;
    int          pop_since_ack = 0;
    logic        prev_ack      = 1'b0;
    logic        prev_busy     = 1'b0;
    logic        prev_cmd_stall  = 1'b0;
    logic        prev_data_stall = 1'b0;
    logic [28:0] prev_addr     = 29'd0;
    logic [127:0] prev_data    = 128'd0;
    logic [15:0] prev_bursts   = 16'd0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_word(input int n);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(n);
        return {w, ~w, w ^ 32'h5A5A_5A5A, 32'(n)};
    endfunction

    task automatic fifo_refresh();
        ifc.fifo_rd_data_count = 9'(fifo_q.size());
        ifc.mem_wdf_data       = (fifo_q.size() != 0) ? fifo_q[0] : 128'd0;
    endtask

    task automatic push_word(input int n);
        logic [127:0] w;
        w = mk_word(n);
        fifo_q.push_back(w);
        exp_data.push_back(w);
        fifo_refresh();
    endtask

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic wait_acks(input int n);
        int b;
        b = 0;
        while (ack_count < n && b < 100) begin
            tick();
            b++;
        end
        chk("ack_timeout", 128'(ack_count >= n), 128'd1);
    endtask

    task automatic wait_bursts(input int n);
        int b;
        b = 0;
        while (burst_count < n && b < 200) begin
            tick();
            b++;
        end
        chk("burst_timeout", 128'(burst_count >= n), 128'd1);
    endtask

    // Cycle counter
    always @(posedge mem_clk) cyc++;

    // FWFT FIFO model: pop after the edge on which rd_en was seen
    always begin
        logic do_pop;
        @(posedge mem_clk);
        do_pop = ifc.mem_wdata_rd_en;
        #1;
        if (do_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
        fifo_refresh();
    end

    // Monitor: pops scoreboard entries whenever the DUT presents a transfer
    always @(negedge mem_clk) begin
        if (mem_reset) begin
            cmd_since_ack   = 0;
            pop_since_ack   = 0;
            prev_ack        = 1'b0;
            prev_busy       = 1'b0;
            prev_cmd_stall  = 1'b0;
            prev_data_stall = 1'b0;
            prev_bursts     = 16'd0;
        end else begin
            if (ifc.mem_wr_ack) begin
                ack_count++;
                last_ack_cyc = cyc;
                ack_cyc_q.push_back(cyc);
                cmd_since_ack = 0;
                pop_since_ack = 0;
                chk("ack_expected", 128'(exp_ack.size() != 0), 128'd1);
                if (exp_ack.size() != 0) chk("ack_addr", ifc.app_addr, exp_ack.pop_front());
                chk("ack_with_app_en", ifc.app_en, 1'b1);
                chk("ack_not_consecutive", prev_ack, 1'b0);
            end
            if (ifc.app_en && prev_cmd_stall) chk("cmd_addr_hold", ifc.app_addr, prev_addr);
            if (ifc.app_wdf_wren && prev_data_stall) chk("data_hold", ifc.app_wdf_data, prev_data);
            if (ifc.app_en && ifc.app_rdy) begin
                cmd_since_ack++;
                chk("cmd_expected", 128'(exp_cmd.size() != 0), 128'd1);
                if (exp_cmd.size() != 0) chk("cmd_addr", ifc.app_addr, exp_cmd.pop_front());
                chk("cmd_is_write", ifc.app_cmd, 3'b000);
            end
            if (ifc.mem_wdata_rd_en) begin
                pop_since_ack++;
                pop_total++;
                chk("pop_expected", 128'(exp_data.size() != 0), 128'd1);
                if (exp_data.size() != 0) chk("wdf_data", ifc.app_wdf_data, exp_data.pop_front());
                chk("wdf_end", ifc.app_wdf_end, 1'b1);
                chk("wdf_mask", ifc.app_wdf_mask, 16'h0000);
            end
            if (ifc.mem_wdata_rd_en !== (ifc.app_wdf_wren & ifc.app_wdf_rdy))
                chk("rd_en_term", ifc.mem_wdata_rd_en, ifc.app_wdf_wren & ifc.app_wdf_rdy);
            if (ifc.bursts_done == prev_bursts + 16'd1) begin
                burst_count++;
                chk("burst_cmds", 128'(cmd_since_ack), 128'(BB));
                chk("burst_pops", 128'(pop_since_ack), 128'(BB));
            end
            if (prev_busy && !ifc.busy) idle_cyc = cyc;
            prev_ack        = ifc.mem_wr_ack;
            prev_busy       = ifc.busy;
            prev_cmd_stall  = ifc.app_en & ~ifc.app_rdy;
            prev_data_stall = ifc.app_wdf_wren & ~ifc.app_wdf_rdy;
            prev_addr       = ifc.app_addr;
            prev_data       = ifc.app_wdf_data;
            prev_bursts     = ifc.bursts_done;
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ack"},     ifc.mem_wr_ack, 1'b0);
        chk({tag, "_rd_en"},   ifc.mem_wdata_rd_en, 1'b0);
        chk({tag, "_app_en"},  ifc.app_en, 1'b0);
        chk({tag, "_wren"},    ifc.app_wdf_wren, 1'b0);
        chk({tag, "_end"},     ifc.app_wdf_end, 1'b0);
        chk({tag, "_busy"},    ifc.busy, 1'b0);
        chk({tag, "_addr"},    ifc.app_addr, 29'd0);
        chk({tag, "_bursts"},  ifc.bursts_done, 16'd0);
        chk({tag, "_cmd"},     ifc.app_cmd, 3'd0);
    endtask

    initial begin
        int raise_cyc;
        int base;
        int b;
        int i;
        mem_clk                 = 1'b0;
        mem_reset               = 1'b0;
        ifc.init_calib_complete = 1'b0;
        ifc.mem_wr_req          = 1'b0;
        ifc.mem_wr_addr         = 29'd0;
        ifc.app_rdy             = 1'b1;
        ifc.app_wdf_rdy         = 1'b1;
        fifo_refresh();
        #2 mem_reset = 1'b1;
        tick();
        tick();
        chk_outputs_zero("reset");
        mem_reset = 1'b0;
        tick();

        // Basic burst
        for (int n = 0; n < 4; n++) push_word(n);
        exp_cmd.push_back(29'h100); exp_cmd.push_back(29'h108);
        exp_cmd.push_back(29'h110); exp_cmd.push_back(29'h118);
        exp_ack.push_back(29'h100);
        ifc.init_calib_complete = 1'b1;
        ifc.mem_wr_addr = 29'h100;
        ifc.mem_wr_req  = 1'b1;
        wait_acks(1);
        ifc.mem_wr_req = 1'b0;
        wait_bursts(1);
        chk("basic_bursts_done", ifc.bursts_done, 16'd1);
        // ack seen in first BURST cycle; 4 BURST + 1 DONE cycles before IDLE
        chk("basic_idle_latency", 128'(idle_cyc - last_ack_cyc), 128'd5);
        chk("basic_busy_low", ifc.busy, 1'b0);

        // Gating: count too low, then calibration low
        for (int n = 10; n < 13; n++) push_word(n);
        ifc.mem_wr_addr = 29'h40;
        ifc.mem_wr_req  = 1'b1;
        repeat (5) tick();
        chk("gate_count_ack", 128'(ack_count), 128'd1);
        chk("gate_count_app_en", ifc.app_en, 1'b0);
        ifc.init_calib_complete = 1'b0;
        push_word(13);
        repeat (5) tick();
        chk("gate_calib_ack", 128'(ack_count), 128'd1);
        chk("gate_calib_app_en", ifc.app_en, 1'b0);
        exp_cmd.push_back(29'h40); exp_cmd.push_back(29'h48);
        exp_cmd.push_back(29'h50); exp_cmd.push_back(29'h58);
        exp_ack.push_back(29'h40);
        ifc.init_calib_complete = 1'b1;
        raise_cyc = cyc;
        wait_acks(2);
        chk("gate_ack_next_edge", 128'(last_ack_cyc), 128'(raise_cyc + 1));
        ifc.mem_wr_req = 1'b0;
        wait_bursts(2);

        // Address wrap
        for (int n = 20; n < 24; n++) push_word(n);
        exp_cmd.push_back(29'h1FFFFFF8); exp_cmd.push_back(29'h0);
        exp_cmd.push_back(29'h8);        exp_cmd.push_back(29'h10);
        exp_ack.push_back(29'h1FFFFFF8);
        ifc.mem_wr_addr = 29'h1FFFFFF8;
        ifc.mem_wr_req  = 1'b1;
        wait_acks(3);
        ifc.mem_wr_req = 1'b0;
        wait_bursts(3);

        // Backpressure on both channels
        for (int n = 30; n < 34; n++) push_word(n);
        exp_cmd.push_back(29'h400); exp_cmd.push_back(29'h408);
        exp_cmd.push_back(29'h410); exp_cmd.push_back(29'h418);
        exp_ack.push_back(29'h400);
        ifc.app_wdf_rdy = 1'b0;
        ifc.mem_wr_addr = 29'h400;
        ifc.mem_wr_req  = 1'b1;
        i = 0;
        while (burst_count < 4 && i < 80) begin
            tick();
            i++;
            if (ack_count >= 4) ifc.mem_wr_req = 1'b0;
            ifc.app_rdy     = ((i % 3) == 1);
            ifc.app_wdf_rdy = (i > 5);
        end
        chk("bp_burst_finished", 128'(burst_count), 128'd4);
        chk("bp_bursts_done", ifc.bursts_done, 16'd4);
        ifc.app_rdy     = 1'b1;
        ifc.app_wdf_rdy = 1'b1;
        ifc.mem_wr_req  = 1'b0;
        tick();

        // Back-to-back with request held high
        for (int n = 40; n < 48; n++) push_word(n);
        exp_cmd.push_back(29'h0);  exp_cmd.push_back(29'h8);
        exp_cmd.push_back(29'h10); exp_cmd.push_back(29'h18);
        exp_cmd.push_back(29'h20); exp_cmd.push_back(29'h28);
        exp_cmd.push_back(29'h30); exp_cmd.push_back(29'h38);
        exp_ack.push_back(29'h0);  exp_ack.push_back(29'h20);
        ifc.mem_wr_addr = 29'h0;
        ifc.mem_wr_req  = 1'b1;
        wait_acks(5);
        ifc.mem_wr_addr = 29'h20;
        wait_acks(6);
        ifc.mem_wr_req = 1'b0;
        if (ack_cyc_q.size() >= 6)
            chk("b2b_ack_spacing", 128'(ack_cyc_q[5] - ack_cyc_q[4]), 128'd6);
        wait_bursts(6);
        chk("b2b_bursts_done", ifc.bursts_done, 16'd6);

        // Reset mid-burst after two beats
        for (int n = 50; n < 54; n++) push_word(n);
        exp_cmd.push_back(29'h600); exp_cmd.push_back(29'h608);
        exp_cmd.push_back(29'h610); exp_cmd.push_back(29'h618);
        exp_ack.push_back(29'h600);
        ifc.mem_wr_addr = 29'h600;
        ifc.mem_wr_req  = 1'b1;
        base = pop_total;
        wait_acks(7);
        ifc.mem_wr_req = 1'b0;
        b = 0;
        while (pop_total < base + 2 && b < 50) begin
            tick();
            b++;
        end
        chk("rst_two_beats_seen", 128'(pop_total - base), 128'd2);
        #2 mem_reset = 1'b1;
        #1;
        chk_outputs_zero("rst_async");
        exp_cmd.delete();
        exp_data.delete();
        exp_ack.delete();
        fifo_q.delete();
        fifo_refresh();
        tick();
        tick();
        mem_reset = 1'b0;
        tick();

        // Normal burst after reset release
        for (int n = 60; n < 64; n++) push_word(n);
        exp_cmd.push_back(29'h700); exp_cmd.push_back(29'h708);
        exp_cmd.push_back(29'h710); exp_cmd.push_back(29'h718);
        exp_ack.push_back(29'h700);
        ifc.mem_wr_addr = 29'h700;
        ifc.mem_wr_req  = 1'b1;
        wait_acks(8);
        ifc.mem_wr_req = 1'b0;
        wait_bursts(7);
        chk("post_rst_bursts_done", ifc.bursts_done, 16'd1);

        repeat (3) tick();
        chk("end_cmd_q_empty",  128'(exp_cmd.size()), 128'd0);
        chk("end_data_q_empty", 128'(exp_data.size()), 128'd0);
        chk("end_ack_q_empty",  128'(exp_ack.size()), 128'd0);
        chk("end_ack_count",    128'(ack_count), 128'd8);
        chk("end_idle",         ifc.busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
